mem_port_arbiter: RTL

//  Shares one external memory bus between the core's I-fetch and D-access ports.

---
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the core-side I-fetch / D-access request ports and the shared
// memory bus into one interface.
//   slave  : arbiter view (takes core requests and memory acks, drives
//            core acks and the memory request bus)
//   master : environment view (core + memory model)
// Core I-port : i_read_en, i_addr -> i_ack, i_data
// Core D-port : d_read_en, d_write_en, d_addr, d_wdata, d_byte_en
//               -> d_ack, d_rdata
// Shared      : bus_error pulses with i_ack/d_ack on a timed-out completion
// Memory      : mem_req, mem_we, mem_addr, mem_wdata, mem_be
//               <- mem_ack, mem_rdata
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int unsigned AddrW = 32,
    parameter int unsigned DataW = 32
);
    localparam int unsigned BeW = DataW / 8;

    logic             i_read_en;
    logic [AddrW-1:0] i_addr;
    logic             i_ack;
    logic [DataW-1:0] i_data;

    logic             d_read_en;
    logic             d_write_en;
    logic [AddrW-1:0] d_addr;
    logic [DataW-1:0] d_wdata;
    logic [BeW-1:0]   d_byte_en;
    logic             d_ack;
    logic [DataW-1:0] d_rdata;

    logic             bus_error;

    logic             mem_req;
    logic             mem_we;
    logic [AddrW-1:0] mem_addr;
    logic [DataW-1:0] mem_wdata;
    logic [BeW-1:0]   mem_be;
    logic             mem_ack;
    logic [DataW-1:0] mem_rdata;

    modport slave (
        input  i_read_en, i_addr,
        input  d_read_en, d_write_en, d_addr, d_wdata, d_byte_en,
        input  mem_ack, mem_rdata,
        output i_ack, i_data, d_ack, d_rdata, bus_error,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output i_read_en, i_addr,
        output d_read_en, d_write_en, d_addr, d_wdata, d_byte_en,
        output mem_ack, mem_rdata,
        input  i_ack, i_data, d_ack, d_rdata, bus_error,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory bus between the core's I-fetch and D-access ports.
// D has priority; after StarveLimit consecutive D grants made while I waits,
// I is granted. A watchdog completes a transaction with data 0 and
// bus_error=1 if memory does not ack within Timeout cycles (0 disables).
// Ports:
//   clk_i   clock, all state on rising edge
//   rst_ni  synchronous reset, active low
//   bus_io  core request/ack ports and memory bus (slave modport)
// Flow: Idle -> BusyI | BusyD -> Resp -> Idle. All outputs are registered.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned AddrW       = 32,
    parameter int unsigned DataW       = 32,
    parameter int unsigned StarveLimit = 4,
    parameter int unsigned Timeout     = 255
) (
    input logic                clk_i,
    input logic                rst_ni,
    mem_port_arbiter_if.slave  bus_io
);
    localparam int unsigned BeW     = DataW / 8;
    localparam int unsigned StarveW = $clog2(StarveLimit + 1);
    // Counter only needs to hold 0 .. Timeout-1.
    localparam int unsigned TmoW    = (Timeout < 2) ? 1 : $clog2(Timeout);
    localparam bit          TmoEn   = (Timeout != 0);

    localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);
    localparam logic [TmoW-1:0]    TmoLast   = TmoW'(Timeout - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusyI = 2'd1;
    localparam logic [1:0] StBusyD = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;

    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [AddrW-1:0]   mem_addr_q, mem_addr_d;
    logic [DataW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BeW-1:0]     mem_be_q, mem_be_d;

    logic               i_ack_q, i_ack_d;
    logic [DataW-1:0]   i_data_q, i_data_d;
    logic               d_ack_q, d_ack_d;
    logic [DataW-1:0]   d_rdata_q, d_rdata_d;
    logic               bus_error_q, bus_error_d;

    logic               d_req;
    logic               grant_d;
    logic               rsp_done;
    logic               rsp_err;
    logic [DataW-1:0]   rsp_data;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_ack_d     = 1'b0;
        i_data_d    = '0;
        d_ack_d     = 1'b0;
        d_rdata_d   = '0;
        bus_error_d = 1'b0;
        rsp_done    = 1'b0;
        rsp_err     = 1'b0;
        rsp_data    = '0;

        d_req   = bus_io.d_read_en | bus_io.d_write_en;
        // D wins unless I has already been passed over StarveLimit times.
        grant_d = d_req & ~(bus_io.i_read_en & (starve_q == StarveMax));

        case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (grant_d) begin
                    state_d     = StBusyD;
                    mem_req_d   = 1'b1;
                    // Read+write together is treated as a write.
                    mem_we_d    = bus_io.d_write_en;
                    mem_addr_d  = bus_io.d_addr;
                    mem_wdata_d = bus_io.d_wdata;
                    mem_be_d    = bus_io.d_write_en ? bus_io.d_byte_en : '1;
                    if (bus_io.i_read_en) begin
                        starve_d = (starve_q == StarveMax) ? starve_q
                                                           : starve_q + StarveW'(1);
                    end else begin
                        starve_d = '0;
                    end
                end else if (bus_io.i_read_en) begin
                    state_d     = StBusyI;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus_io.i_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    starve_d    = '0;
                end else begin
                    starve_d = '0;
                end
            end

            StBusyI, StBusyD: begin
                // A real ack beats the watchdog on the terminal-count cycle.
                if (bus_io.mem_ack) begin
                    rsp_done = 1'b1;
                    rsp_data = bus_io.mem_rdata;
                end else if (TmoEn && (tmo_q == TmoLast)) begin
                    rsp_done = 1'b1;
                    rsp_err  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end

                if (rsp_done) begin
                    state_d     = StResp;
                    mem_req_d   = 1'b0;
                    bus_error_d = rsp_err;
                    if (state_q == StBusyI) begin
                        i_ack_d  = 1'b1;
                        i_data_d = rsp_data;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rsp_data;
                    end
                end
            end

            StResp: begin
                // Requests still held by the acked port are ignored here.
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_ack_q     <= 1'b0;
            i_data_q    <= '0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_ack_q     <= i_ack_d;
            i_data_q    <= i_data_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_io.mem_req   = mem_req_q;
    assign bus_io.mem_we    = mem_we_q;
    assign bus_io.mem_addr  = mem_addr_q;
    assign bus_io.mem_wdata = mem_wdata_q;
    assign bus_io.mem_be    = mem_be_q;
    assign bus_io.i_ack     = i_ack_q;
    assign bus_io.i_data    = i_data_q;
    assign bus_io.d_ack     = d_ack_q;
    assign bus_io.d_rdata   = d_rdata_q;
    assign bus_io.bus_error = bus_error_q;

endmodule
